// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Word-array memory behind the LC-3b single-port interface with
//            programmable wait states and a one-cycle resp_b pulse.
//            Optional protocol checker: define MEM_RESPONDER_PROTO_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
    ,
    output logic        proto_err
`endif
);

    localparam int         DEPTH      = 1 << ADDR_BITS;
    localparam logic [3:0] C_CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [1:0]  r_mask;
    logic [15:0] r_wdata;
    logic [15:0] r_mem [0:DEPTH-1];

    logic                 w_req;
    logic                 w_accept;
    logic                 w_enter_resp;
    logic                 w_sel_wr;
    logic [ADDR_BITS-1:0] w_sel_idx;
    logic [1:0]           w_sel_mask;
    logic [15:0]          w_sel_data;
    logic                 w_unused_addr;

    assign w_req    = read_b | write_b;
    assign w_accept = (r_state == S_IDLE) && w_req;

    // With zero latency the commit happens on the accepting edge, so the
    // live request fields are used instead of the (not yet loaded) captures.
    assign w_sel_wr   = (r_state == S_IDLE) ? write_b                  : r_wr;
    assign w_sel_idx  = (r_state == S_IDLE) ? address_b[ADDR_BITS:1]   : r_addr[ADDR_BITS:1];
    assign w_sel_mask = (r_state == S_IDLE) ? wmask_b                  : r_mask;
    assign w_sel_data = (r_state == S_IDLE) ? wdata_b                  : r_wdata;

    assign w_enter_resp = reset_n &&
                          ((w_accept && (LATENCY == 0)) ||
                           ((r_state == S_WAIT) && w_req && (r_cnt == 4'd0)));

    assign w_unused_addr = ^r_addr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            resp_b  <= 1'b0;
            rdata_b <= 16'h0000;
        end else begin
            resp_b <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_wr    <= write_b;
                        r_addr  <= address_b;
                        r_mask  <= wmask_b;
                        r_wdata <= wdata_b;
                        r_cnt   <= C_CNT_INIT;
                        r_state <= (LATENCY == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_enter_resp) begin
                resp_b <= 1'b1;
                if (!w_sel_wr) begin
                    rdata_b <= r_mem[w_sel_idx];
                end
            end
        end
    end

    // Storage has no reset; only lanes enabled by the captured mask change.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_sel_wr) begin
            if (w_sel_mask[0]) r_mem[w_sel_idx][7:0]  <= w_sel_data[7:0];
            if (w_sel_mask[1]) r_mem[w_sel_idx][15:8] <= w_sel_data[15:8];
        end
    end

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
    logic w_both;
    logic w_abort;
    logic w_changed;

    assign w_both    = read_b && write_b &&
                       ((r_state == S_IDLE) || (r_state == S_WAIT));
    assign w_abort   = (r_state == S_WAIT) && !w_req;
    assign w_changed = (r_state == S_WAIT) &&
                       ((address_b != r_addr) || (wdata_b != r_wdata) ||
                        (wmask_b != r_mask));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            proto_err <= 1'b0;
        end else if (w_both || w_abort || w_changed) begin
            proto_err <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder (LATENCY 2 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        rd = 1'b0, wr = 1'b0;
    logic [1:0]  mask = 2'b00;
    logic [15:0] addr = 16'h0, wdata = 16'h0;
    logic        resp;
    logic [15:0] rdata;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [1:0]  mask0 = 2'b00;
    logic [15:0] addr0 = 16'h0, wdata0 = 16'h0;
    logic        resp0;
    logic [15:0] rdata0;

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
    logic        perr;
    logic        perr0;
`endif

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(8), .LATENCY(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .read_b    (rd),
        .write_b   (wr),
        .wmask_b   (mask),
        .address_b (addr),
        .wdata_b   (wdata),
        .resp_b    (resp),
        .rdata_b   (rdata)
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        ,
        .proto_err (perr)
`endif
    );

    mem_responder #(.ADDR_BITS(8), .LATENCY(0)) dut0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .read_b    (rd0),
        .write_b   (wr0),
        .wmask_b   (mask0),
        .address_b (addr0),
        .wdata_b   (wdata0),
        .resp_b    (resp0),
        .rdata_b   (rdata0)
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        ,
        .proto_err (perr0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel0, input bit r, input bit w, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        if (sel0) begin
            rd0 = r; wr0 = w; addr0 = a; wdata0 = d; mask0 = m;
        end else begin
            rd = r; wr = w; addr = a; wdata = d; mask = m;
        end
    endtask

    // One handshake: request from a negedge, held until resp is seen,
    // checks latency and pulse width. Optionally disturbs fields in WAIT.
    task automatic xact(input string tag, input bit sel0, input bit r, input bit w,
                        input logic [15:0] a, input logic [15:0] d, input logic [1:0] m,
                        input int lat, input bit perturb, output logic [15:0] rdat);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        drive(sel0, r, w, a, d, m);
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = sel0 ? resp0 : resp;
            if (!seen && perturb && n == 1) drive(sel0, r, w, a ^ 16'h0F0E, ~d, ~m);
        end
        rdat = sel0 ? rdata0 : rdata;
        drive(sel0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        chk({tag, "_latency"}, n, lat + 1);
        @(negedge clk);
        chk({tag, "_pulse"}, sel0 ? resp0 : resp, 1'b0);
    endtask

    task automatic watch_no_resp(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (resp) seen = 1'b1;
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        logic [15:0] d;

        // Reset for two edges
        @(negedge clk);
        @(negedge clk);
        chk("reset_resp", resp, 1'b0);
        chk("reset_rdata", rdata, 16'h0000);
        reset_n = 1'b1;
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        chk("reset_proto", perr, 1'b0);
`endif

        xact("wr_zero", 0, 0, 1, 16'h0010, 16'h0000, 2'b11, 2, 0, d);
        xact("rd_zero", 0, 1, 0, 16'h0010, 16'h0000, 2'b00, 2, 0, d);
        chk("rd_zero_data", d, 16'h0000);

        xact("wr_beef", 0, 0, 1, 16'h0020, 16'hBEEF, 2'b11, 2, 0, d);
        xact("rd_beef", 0, 1, 0, 16'h0021, 16'h0000, 2'b00, 2, 0, d);
        chk("rd_beef_data", d, 16'hBEEF);

        xact("wr_1234", 0, 0, 1, 16'h0030, 16'h1234, 2'b11, 2, 0, d);
        xact("wr_hi",   0, 0, 1, 16'h0030, 16'hAB00, 2'b10, 2, 0, d);
        xact("wr_lo",   0, 0, 1, 16'h0030, 16'h00CD, 2'b01, 2, 0, d);
        xact("rd_lanes", 0, 1, 0, 16'h0030, 16'h0000, 2'b11, 2, 0, d);
        chk("rd_lanes_data", d, 16'hABCD);
        xact("wr_m00",  0, 0, 1, 16'h0030, 16'hFFFF, 2'b00, 2, 0, d);
        chk("rdata_hold", rdata, 16'hABCD);
        xact("rd_m00", 0, 1, 0, 16'h0030, 16'h0000, 2'b00, 2, 0, d);
        chk("rd_m00_data", d, 16'hABCD);

        // Abort: drop read after one WAIT cycle
        drive(0, 1, 0, 16'h0020, 16'h0, 2'b00);
        @(negedge clk);
        drive(0, 0, 0, 16'h0, 16'h0, 2'b00);
        watch_no_resp("abort_no_resp", 6);
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        chk("abort_proto", perr, 1'b1);
`endif
        xact("after_abort", 0, 1, 0, 16'h0020, 16'h0000, 2'b00, 2, 0, d);
        chk("after_abort_data", d, 16'hBEEF);

        // Reset during a write's WAIT
        drive(0, 0, 1, 16'h0030, 16'h9999, 2'b11);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 16'h0, 16'h0, 2'b00);
        chk("rst_mid_rdata", rdata, 16'h0000);
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        chk("rst_mid_proto", perr, 1'b0);
`endif
        watch_no_resp("rst_mid_no_resp", 5);
        xact("rst_mid_rd", 0, 1, 0, 16'h0030, 16'h0000, 2'b00, 2, 0, d);
        chk("rst_mid_data", d, 16'hABCD);

        // Both read_b and write_b: write wins
        xact("both", 0, 1, 1, 16'h0060, 16'h7777, 2'b11, 2, 0, d);
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        chk("both_proto", perr, 1'b1);
`endif
        xact("both_rd", 0, 1, 0, 16'h0060, 16'h0000, 2'b00, 2, 0, d);
        chk("both_data", d, 16'h7777);
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        chk("proto_sticky", perr, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("proto_cleared", perr, 1'b0);
`endif

        // Field changes during WAIT are ignored
        xact("perturb", 0, 0, 1, 16'h0040, 16'h1111, 2'b11, 2, 1, d);
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        chk("perturb_proto", perr, 1'b1);
`endif
        xact("perturb_rd", 0, 1, 0, 16'h0040, 16'h0000, 2'b00, 2, 0, d);
        chk("perturb_data", d, 16'h1111);

        // Zero latency instance, plus address aliasing
        xact("l0_wr", 1, 0, 1, 16'h0202, 16'h5555, 2'b11, 0, 0, d);
        xact("l0_rd", 1, 1, 0, 16'h0002, 16'h0000, 2'b00, 0, 0, d);
        chk("l0_alias_data", d, 16'h5555);
        xact("l0_wr2", 1, 0, 1, 16'h0004, 16'hC3A5, 2'b01, 0, 0, d);
        xact("l0_rd2", 1, 1, 0, 16'h0005, 16'h0000, 2'b00, 0, 0, d);
        chk("l0_lane_data", d[7:0], 8'hA5);
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
        chk("l0_proto", perr0, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the LC-3b single-port memory interface (read_b/write_b/wmask_b/address_b/wdata_b in, resp_b/rdata_b out) driven by the datapath MAR/MDR.
- Backs the port with a local word-organised array and inserts a programmable number of wait states.
- Accepts one transaction at a time and answers with a one-cycle resp_b pulse.
- Serves as the fabric-side memory for simulation and for small FPGA builds.

Parameters:
- ADDR_BITS, 8: number of word-address bits; the array holds 2^ADDR_BITS 16-bit words, indexed by address_b[ADDR_BITS:1].
- LATENCY, 2: wait cycles between request acceptance and resp_b; legal range 0..15.

Ports:
- clk  input  1: clock; all state changes on the rising edge.
- reset_n  input  1: synchronous, active-low reset.
- read_b  input  1: read request; held high by the requester until resp_b is seen.
- write_b  input  1: write request; held high by the requester until resp_b is seen.
- wmask_b  input  2: byte-lane write enables; [0] selects bits 7:0, [1] selects bits 15:8.
- address_b  input  16: byte address; bit 0 is ignored; bits above ADDR_BITS are ignored, so the array aliases.
- wdata_b  input  16: write data.
- resp_b  output  1: one-cycle completion pulse.
- rdata_b  output  16: read data, valid while resp_b=1.

Behaviour:
- Reset: on a clock edge with reset_n=0, the FSM goes to IDLE, resp_b=0, rdata_b=0 and the wait counter=0. Array contents are not reset. Reset mid-transaction aborts it with no write commit and no resp_b.
- FSM states: IDLE, WAIT, RESP. resp_b and rdata_b are registered outputs.
- IDLE, when (read_b|write_b)=1 at an edge:
  - Capture the operation, word index, wmask_b and wdata_b.
  - LATENCY=0: go to RESP. Otherwise: go to WAIT with counter=LATENCY-1.
- WAIT:
  - If read_b|write_b drops at an edge, abort to IDLE: no commit, no resp_b.
  - Else if counter=0, go to RESP. Else decrement the counter.
- Commit, on the edge entering RESP:
  - Write: update only the lanes whose wmask_b bit was 1. wmask_b=00 changes nothing but still responds.
  - Read: load rdata_b with the full word from the captured index; the mask is ignored.
- RESP:
  - resp_b=1 for exactly one cycle, then IDLE unconditionally.
  - The request still high during the RESP cycle is not treated as new. IDLE samples again on the following edge, so there is at least one dead cycle between transactions.
- Latency: a request first sampled at edge T produces resp_b high in the cycle after edge T+LATENCY. Total turnaround is LATENCY+1 cycles.
- Hold rules:
  - rdata_b holds its last value outside RESP, including after writes, which do not update it.
  - Captured inputs are used throughout; changes on address_b, wdata_b or wmask_b during WAIT have no effect.
- read_b and write_b both high at acceptance: treated as a write.
- Read-after-write to the same word in back-to-back transactions returns the new data.

Optional Feature:
- Macro MEM_RESPONDER_PROTO_CHECK_EN.
- Defined: adds output proto_err (1 bit), reset to 0 and sticky until reset. It is set on the edge after any of:
  - read_b&write_b=1 while in IDLE or WAIT;
  - an abort in WAIT;
  - address_b, wdata_b or wmask_b differing from the captured values during WAIT.
  - Datapath behaviour is otherwise unchanged.
- Undefined: no proto_err port and no checking logic.

Test Plan:
- Reset then read, LATENCY=2: hold reset_n=0 for 2 cycles, then read_b=1 with address_b=0x0010 -> resp_b high in the third cycle after acceptance for exactly one cycle, rdata_b=0x0000 if the array was preloaded with zeros.
- Full write then read: write 0xBEEF to 0x0020 with wmask_b=11, then read 0x0021 -> rdata_b=0xBEEF (bit 0 ignored).
- Byte lanes: write 0x1234 with wmask_b=11, then 0xAB00 with mask 10, then 0x00CD with mask 01, then read -> 0xABCD. A write with mask 00 -> resp_b still pulses and the word is unchanged.
- Abort and reset: drop read_b after 1 WAIT cycle -> no resp_b, FSM back in IDLE. Assert reset_n=0 during a write's WAIT -> no resp_b and the target word is unchanged on readback.
- LATENCY=0 and aliasing: read -> resp_b in the cycle after acceptance. With ADDR_BITS=8, write 0x5555 to 0x0202, then read 0x0002 -> 0x5555.
- With MEM_RESPONDER_PROTO_CHECK_EN: read_b=write_b=1 -> write performed and proto_err=1, staying 1 until reset. Changing address_b during WAIT also sets proto_err=1.
